// File: rtl/pcie_reset_pkg.sv
// -----------------------------------------------------------------------------
// pcie_reset_pkg
// Shared definitions for the PCIe reset sequencer:
//   - seq_state_e      : 3-bit sequencer state encoding (codes 6/7 unused)
//   - DEF_*            : default synchroniser depth and sequencing delays
//   - LOSS_CNT_W       : width of the status-loss event counter
//   - loss_cnt_inc()   : saturating increment for the loss counter
// -----------------------------------------------------------------------------
package pcie_reset_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_STAGE_DELAY   = 64;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_STABLE = 3'd1,
        ST_REL_FABRIC  = 3'd2,
        ST_REL_PCIE    = 3'd3,
        ST_REL_USER    = 3'd4,
        ST_RUN         = 3'd5
    } seq_state_e;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] loss_cnt_inc(input logic [LOSS_CNT_W-1:0] val);
        logic [LOSS_CNT_W-1:0] res;
        if (val == {LOSS_CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + LOSS_CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pcie_reset_sequencer_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Single-bit multi-flop synchroniser for an asynchronous level input.
// Ports:
//   clk_i  in  sampling clock
//   rst_i  in  synchronous active-high reset, clears every stage to 0
//   d_i    in  asynchronous input
//   q_o    out synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_bit: STAGES must be >= 2");
        end
    endgenerate

    logic [STAGES-1:0] sync_q;

    // Shift chain: stage 0 samples the async input, the last stage feeds logic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pcie_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pcie_reset_sequencer
// Releases fabric, PCIe-core and user resets in a fixed timed order once the
// four asynchronous device-status inputs have been stably high, and pulls all
// three resets back together whenever any status input drops.
// Ports:
//   CLK_125MHz            in   free-running reference clock
//   RESET                 in   synchronous active-high reset
//   FABRIC_POR_N          in   async, high = fabric POR released
//   DEVICE_INIT_DONE      in   async, high = device init complete
//   BANK0_1_4_CALIB_DONE  in   async, high = IO bank calibration done
//   PLL_LOCK              in   async, high = fabric PLL locked
//   FABRIC_RESET_N        out  fabric reset, active-low
//   PCIE_CORE_RESET_N     out  PCIe core reset, active-low
//   USER_RESET_N          out  user reset, active-low
//   SEQ_DONE              out  high while in RUN
//   SEQ_STATE             out  current state encoding
//   INIT_LOSS_CNT         out  saturating count of status-loss events
// -----------------------------------------------------------------------------
module pcie_reset_sequencer
    import pcie_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_DELAY   = DEF_STAGE_DELAY
) (
    input  logic                  CLK_125MHz,
    input  logic                  RESET,
    input  logic                  FABRIC_POR_N,
    input  logic                  DEVICE_INIT_DONE,
    input  logic                  BANK0_1_4_CALIB_DONE,
    input  logic                  PLL_LOCK,
    output logic                  FABRIC_RESET_N,
    output logic                  PCIE_CORE_RESET_N,
    output logic                  USER_RESET_N,
    output logic                  SEQ_DONE,
    output logic [2:0]            SEQ_STATE,
    output logic [LOSS_CNT_W-1:0] INIT_LOSS_CNT
);

    localparam int CNT_MAX = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pcie_reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("pcie_reset_sequencer: STABLE_CYCLES must be >= 1");
        end
        if (STAGE_DELAY < 1) begin : g_bad_delay
            $error("pcie_reset_sequencer: STAGE_DELAY must be >= 1");
        end
    endgenerate

    // ---------------------------------------------------------------- sync
    logic por_sync;
    logic init_sync;
    logic calib_sync;
    logic pll_sync;
    logic all_ok;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_por (
        .clk_i (CLK_125MHz),
        .rst_i (RESET),
        .d_i   (FABRIC_POR_N),
        .q_o   (por_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
        .clk_i (CLK_125MHz),
        .rst_i (RESET),
        .d_i   (DEVICE_INIT_DONE),
        .q_o   (init_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_calib (
        .clk_i (CLK_125MHz),
        .rst_i (RESET),
        .d_i   (BANK0_1_4_CALIB_DONE),
        .q_o   (calib_sync)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pll (
        .clk_i (CLK_125MHz),
        .rst_i (RESET),
        .d_i   (PLL_LOCK),
        .q_o   (pll_sync)
    );

    assign all_ok = por_sync & init_sync & calib_sync & pll_sync;

    // ---------------------------------------------------------------- state
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  fab_q, fab_d;
    logic                  pcie_q, pcie_d;
    logic                  user_q, user_d;
    logic                  done_q, done_d;

    // Next-state, counter and loss-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_STABLE;
                cnt_d   = '0;
            end
            ST_WAIT_STABLE: begin
                if (!all_ok) begin
                    // a drop while still qualifying is not a loss event
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_REL_FABRIC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL_FABRIC, ST_REL_PCIE, ST_REL_USER: begin
                if (!all_ok) begin
                    state_d = ST_WAIT_STABLE;
                    cnt_d   = '0;
                    loss_d  = loss_cnt_inc(loss_q);
                end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    cnt_d = '0;
                    if (state_q == ST_REL_FABRIC) begin
                        state_d = ST_REL_PCIE;
                    end else if (state_q == ST_REL_PCIE) begin
                        state_d = ST_REL_USER;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!all_ok) begin
                    state_d = ST_WAIT_STABLE;
                    cnt_d   = '0;
                    loss_d  = loss_cnt_inc(loss_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // unused codes recover through IDLE
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs move on the state edge.
    always_comb begin
        fab_d  = 1'b0;
        pcie_d = 1'b0;
        user_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_REL_FABRIC: begin
                fab_d = 1'b1;
            end
            ST_REL_PCIE: begin
                fab_d  = 1'b1;
                pcie_d = 1'b1;
            end
            ST_REL_USER: begin
                fab_d  = 1'b1;
                pcie_d = 1'b1;
                user_d = 1'b1;
            end
            ST_RUN: begin
                fab_d  = 1'b1;
                pcie_d = 1'b1;
                user_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                fab_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; RESET overrides any loss event.
    always_ff @(posedge CLK_125MHz) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            loss_q  <= '0;
            fab_q   <= 1'b0;
            pcie_q  <= 1'b0;
            user_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            fab_q   <= fab_d;
            pcie_q  <= pcie_d;
            user_q  <= user_d;
            done_q  <= done_d;
        end
    end

    assign FABRIC_RESET_N    = fab_q;
    assign PCIE_CORE_RESET_N = pcie_q;
    assign USER_RESET_N      = user_q;
    assign SEQ_DONE          = done_q;
    assign SEQ_STATE         = state_q;
    assign INIT_LOSS_CNT     = loss_q;

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pcie_reset_sequencer
// Directed stimulus against pcie_reset_sequencer with default parameters.
// A progress-based reference model (consecutive all-good cycles since the
// last restart) predicts every output each cycle; literal timing checks pin
// the release/loss cycle numbers.
// -----------------------------------------------------------------------------
module tb_pcie_reset_sequencer;

    localparam int SS = 2;
    localparam int S  = 256;
    localparam int D  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       por = 1'b0;
    logic       init = 1'b0;
    logic       calib = 1'b0;
    logic       pll = 1'b0;
    logic       fab_n, pcie_n, user_n, done;
    logic [2:0] state;
    logic [7:0] loss;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    always #4 clk = ~clk;

    pcie_reset_sequencer dut (
        .CLK_125MHz           (clk),
        .RESET                (rst),
        .FABRIC_POR_N         (por),
        .DEVICE_INIT_DONE     (init),
        .BANK0_1_4_CALIB_DONE (calib),
        .PLL_LOCK             (pll),
        .FABRIC_RESET_N       (fab_n),
        .PCIE_CORE_RESET_N    (pcie_n),
        .USER_RESET_N         (user_n),
        .SEQ_DONE             (done),
        .SEQ_STATE            (state),
        .INIT_LOSS_CNT        (loss)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ model
    // p = consecutive all-good cycles seen since the sequence last restarted.
    bit pipe [SS];
    int p      = 0;
    bit idle   = 1'b1;
    int m_loss = 0;
    bit ok_now;

    always @(posedge clk) begin
        ok_now = pipe[SS-1];
        if (rst) begin
            for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
            p      = 0;
            idle   = 1'b1;
            m_loss = 0;
        end else begin
            for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = por & init & calib & pll;
            if (idle) begin
                idle = 1'b0;
            end else if (ok_now) begin
                if (p < S + 3 * D) p++;
            end else begin
                if (p >= S && m_loss < 255) m_loss++;
                p = 0;
            end
        end
    end

    function automatic int exp_state();
        if (idle)            return 0;
        if (p < S)           return 1;
        if (p < S + D)       return 2;
        if (p < S + 2 * D)   return 3;
        if (p < S + 3 * D)   return 4;
        return 5;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [14:0] got, exp;
            got = {fab_n, pcie_n, user_n, done, state, loss};
            exp = {1'(p >= S), 1'(p >= S + D), 1'(p >= S + 2 * D), 1'(p >= S + 3 * D),
                   3'(exp_state()), 8'(m_loss)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL model cyc=%0d got fab/pcie/user/done=%b state=%0d loss=%0d, expected %b state=%0d loss=%0d",
                             cyc, got[14:11], got[10:8], got[7:0], exp[14:11], exp[10:8], exp[7:0]);
            end
        end
    end

    // ------------------------------------------------------------ edge log
    int   rise_cyc [4];
    int   fall_cyc [4];
    int   user_rises = 0;
    logic [3:0] prev_o = 4'bxxxx;

    always @(negedge clk) begin
        logic [3:0] cur;
        cur = {done, user_n, pcie_n, fab_n};
        for (int i = 0; i < 4; i++) begin
            if (cur[i] === 1'b1 && prev_o[i] === 1'b0) begin
                rise_cyc[i] = cyc;
                if (i == 2) user_rises++;
            end
            if (cur[i] === 1'b0 && prev_o[i] === 1'b1) fall_cyc[i] = cyc;
        end
        prev_o = cur;
    end

    // ------------------------------------------------------------ helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_all(input logic v);
        por = v; init = v; calib = v; pll = v;
    endtask

    task automatic wait_fabric(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (fab_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int t0, td, ur;
        bit ok;

        // Defaults: 5 reset cycles, then all inputs together.
        tick(1);
        chk_en = 1'b1;
        tick(4);
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({fab_n, pcie_n, user_n, done}), 0);
        check("reset_loss", int'(loss), 0);
        rst = 1'b0;
        tick(1);
        set_all(1'b1);
        t0 = cyc;
        tick(460);
        check("fabric_rise", rise_cyc[0] - t0, 258);
        check("pcie_rise", rise_cyc[1] - t0, 322);
        check("user_rise", rise_cyc[2] - t0, 386);
        check("done_rise", rise_cyc[3] - t0, 450);
        check("run_state", int'(state), 5);

        // Loss in RUN, then full re-sequence.
        init = 1'b0;
        td = cyc;
        tick(4);
        check("run_loss_outputs", int'({fab_n, pcie_n, user_n, done}), 0);
        check("run_loss_fall", fall_cyc[0] - td, 3);
        check("run_loss_state", int'(state), 1);
        check("run_loss_cnt", int'(loss), 1);
        init = 1'b1;
        t0 = cyc;
        tick(460);
        check("re_fabric_rise", rise_cyc[0] - t0, 258);
        check("re_pcie_rise", rise_cyc[1] - t0, 322);
        check("re_user_rise", rise_cyc[2] - t0, 386);
        check("re_done_rise", rise_cyc[3] - t0, 450);

        // Loss while in REL_PCIE.
        init = 1'b0;
        tick(4);
        init = 1'b1;
        t0 = cyc;
        tick(332);
        check("rel_pcie_state", int'(state), 3);
        ur = user_rises;
        calib = 1'b0;
        td = cyc;
        tick(6);
        check("mid_fabric_fall", fall_cyc[0] - td, 3);
        check("mid_pcie_fall", fall_cyc[1] - td, 3);
        check("mid_user_no_pulse", user_rises, ur);
        check("mid_loss_cnt", int'(loss), 3);

        // RESET in REL_USER coinciding with a loss.
        calib = 1'b1;
        tick(391);
        check("rel_user_state", int'(state), 4);
        por = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_mid_state", int'(state), 0);
        check("rst_mid_outputs", int'({fab_n, pcie_n, user_n, done}), 0);
        check("rst_mid_loss", int'(loss), 0);
        tick(1);

        // Glitch during stabilisation.
        rst = 1'b0;
        por = 1'b1;
        t0 = cyc;
        tick(100);
        pll = 1'b0;
        tick(3);
        pll = 1'b1;
        tick(300);
        check("glitch_fabric_rise", rise_cyc[0] - t0, 361);
        check("glitch_loss", int'(loss), 0);

        // Saturation: 260 loss events.
        for (int k = 0; k < 260; k++) begin
            wait_fabric(ok);
            if (!ok) begin
                check("sat_fabric_timeout", 0, 1);
                break;
            end
            pll = 1'b0;
            tick(3);
            pll = 1'b1;
        end
        tick(20);
        check("sat_loss", int'(loss), 255);
        tick(300);
        check("sat_hold", int'(loss), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pcie_reset_sequencer.md
# pcie_reset_sequencer

Consumes the asynchronous device-initialisation status signals produced by the PCIe init/clock block (FABRIC_POR_N, DEVICE_INIT_DONE, BANK0_1_4_CALIB_DONE) plus a fabric PLL lock. It releases fabric, PCIe-core and user resets in a fixed, timed order once all of them are stably asserted. It runs on the free-running 125 MHz reference. It tears all resets down again whenever any status input drops, and counts those loss events for debug.

## Interface
- SYNC_STAGES, 2, synchroniser depth per status input; must be ≥ 2
- STABLE_CYCLES, 256, consecutive cycles all status inputs must be high before release starts; must be ≥ 1
- STAGE_DELAY, 64, cycles between successive reset releases; must be ≥ 1
- CLK_125MHz  in  1  sole clock
- RESET  in  1  synchronous, active-high reset
- FABRIC_POR_N  in  1  async, high = fabric POR released
- DEVICE_INIT_DONE  in  1  async, high = device init complete
- BANK0_1_4_CALIB_DONE  in  1  async, high = IO bank calibration complete
- PLL_LOCK  in  1  async, high = fabric PLL locked
- FABRIC_RESET_N  out  1  fabric logic reset, active-low
- PCIE_CORE_RESET_N  out  1  PCIe core/TL reset, active-low
- USER_RESET_N  out  1  user application reset, active-low
- SEQ_DONE  out  1  high while in RUN
- SEQ_STATE  out  3  current state encoding
- INIT_LOSS_CNT  out  8  saturating count of status-loss events

## Operation
- Each of the 4 async inputs passes through its own SYNC_STAGES flop synchroniser. all_ok is the AND of the 4 synchronised bits.
- States and encodings: IDLE=0, WAIT_STABLE=1, REL_FABRIC=2, REL_PCIE=3, REL_USER=4, RUN=5. Codes 6 and 7 are unused and return to IDLE.
- IDLE: go to WAIT_STABLE on the first cycle with RESET low.
- WAIT_STABLE:
  - The counter increments while all_ok is high.
  - The counter clears to 0 on any cycle with all_ok low.
  - When the counter equals STABLE_CYCLES-1 and all_ok is high, go to REL_FABRIC.
- REL_FABRIC, REL_PCIE, REL_USER:
  - The counter clears on entry.
  - After STAGE_DELAY cycles in the state, go to the next state; REL_USER goes to RUN.
- Outputs are registered and decoded from the next state, so each output changes on the same edge as the state change:
  - FABRIC_RESET_N is 1 in REL_FABRIC and every later state.
  - PCIE_CORE_RESET_N is 1 in REL_PCIE and later.
  - USER_RESET_N is 1 in REL_USER and later.
  - SEQ_DONE is 1 only in RUN.
- Loss event:
  - Trigger: all_ok is low in any of REL_FABRIC, REL_PCIE, REL_USER or RUN.
  - On the next edge, all three resets go to 0, SEQ_DONE goes to 0, the state goes to WAIT_STABLE and the counter is cleared.
  - INIT_LOSS_CNT increments and saturates at 255.
  - A drop while in WAIT_STABLE only clears the counter and is not counted.
- Reset release order is always FABRIC → PCIE → USER. Reassertion is simultaneous for all three.
- RESET takes priority over everything, including a simultaneous loss event.
  - On RESET: state=IDLE, counter=0, all synchroniser flops=0, all outputs 0, INIT_LOSS_CNT=0.
  - RESET asserted mid-sequence behaves identically; there is no partial release.
- The counter width is CNT_W = clog2(max(STABLE_CYCLES, STAGE_DELAY)+1). The counter never wraps, because the state exits before the counter reaches its limit.

## Timing
- Latency from an input edge to all_ok: SYNC_STAGES cycles, or SYNC_STAGES+1 if the edge misses setup.
- Let N be the first cycle with all_ok high, with all_ok staying high afterwards:
  - FABRIC_RESET_N rises at N+STABLE_CYCLES.
  - PCIE_CORE_RESET_N rises at N+STABLE_CYCLES+STAGE_DELAY.
  - USER_RESET_N rises at N+STABLE_CYCLES+2·STAGE_DELAY.
  - SEQ_DONE rises at N+STABLE_CYCLES+3·STAGE_DELAY.
- Loss event: if all_ok goes low at cycle M, all outputs are 0 at M+1.
- Worst case from a raw input fall to the resets asserting: SYNC_STAGES+2 cycles.

## Structure
- Package pcie_reset_pkg holds:
  - the state enum (3-bit) with the encodings above;
  - the default values of SYNC_STAGES, STABLE_CYCLES and STAGE_DELAY;
  - the loss counter width (8).
- Sub-module sync_bit: a parameterised SYNC_STAGES-deep single-bit synchroniser with synchronous active-high reset to 0, instanced 4 times.
- Elaboration-time checks enforce the parameter minimums.

## Test plan
- Defaults. Hold RESET for 5 cycles, release it, then raise all 4 inputs together at cycle 0 → FABRIC_RESET_N=1 at cycle 258, PCIE_CORE_RESET_N=1 at 322, USER_RESET_N=1 at 386, SEQ_DONE=1 and SEQ_STATE=5 at 450.
- Glitch during stabilisation. From the full-release setup, drop PLL_LOCK for 3 cycles at cycle 100 → the counter restarts and FABRIC_RESET_N rises 256 cycles after all_ok returns; INIT_LOSS_CNT stays 0.
- Loss in RUN. Drop DEVICE_INIT_DONE → all resets are 0 within 4 cycles, SEQ_STATE=1 and INIT_LOSS_CNT=1. Restore the input → the full sequence repeats with the same spacing.
- Loss mid-release. Drop BANK0_1_4_CALIB_DONE while in REL_PCIE → PCIE_CORE_RESET_N and FABRIC_RESET_N both go to 0 on the same edge, USER_RESET_N never pulses, and INIT_LOSS_CNT increments.
- Saturation. Force 260 loss events → INIT_LOSS_CNT reads 255 and holds.
- RESET mid-sequence. Assert RESET in REL_USER on the same cycle as an input drop → the next cycle shows SEQ_STATE=0, all outputs 0 and INIT_LOSS_CNT=0.
